huffman_decoder: RTL

Bit-serial Huffman decoder: the receive-side counterpart of the Huffman coder. It accepts packed 32-bit encoded words with a valid/ready handshake and searches a 64-entry code table for the codeword at the head of a bit buffer. Each decoded symbol index is emitted on a valid/ready output. The code table holds `{length, code}` entries in the same 12-bit format the coder's LUT uses, so one table image drives both ends.

---
 rtl/huffman_pkg.sv | 51 +++++
 rtl/huffman_code_table.sv | 25 ++
 rtl/huffman_decoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman decoder: widths, FSM encoding,
// code-table entry layout and the codeword match helper.
package huffman_pkg;

  localparam int WORD_W    = 32;
  localparam int SYM_W     = 6;
  localparam int CODE_W    = 8;
  localparam int LEN_W     = 4;

  localparam int TBL_DEPTH = 32'd1 << SYM_W;
  localparam int TBL_W     = LEN_W + CODE_W;
  localparam int BUF_W     = 40;
  localparam int CNT_W     = 6;
  localparam int SCAN_W    = SYM_W + 1;
  localparam int STAT_W    = 16;

  // Table entry layout: {length, right-aligned code}
  localparam int LEN_MSB   = 11;
  localparam int LEN_LSB   = 8;
  localparam int CODE_MSB  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_EMIT   = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  // True when the entry is a usable codeword (length 1..8), fits in the
  // buffered bits, and its code equals the leading bits of the buffer.
  function automatic logic code_match(
    input logic [TBL_W-1:0]  entry,
    input logic [CODE_W-1:0] head,
    input logic [CNT_W-1:0]  count
  );
    logic [LEN_W-1:0]  len;
    logic [CODE_W-1:0] mask;
    logic [CODE_W-1:0] head_al;
    len     = entry[LEN_MSB:LEN_LSB];
    mask    = ~(8'hFF << len);
    head_al = head >> (4'd8 - len);
    if ((len == 4'd0) || (len > 4'd8)) begin
      code_match = 1'b0;
    end else if ({2'b00, len} > count) begin
      code_match = 1'b0;
    end else begin
      code_match = (head_al == (entry[CODE_MSB:0] & mask));
    end
  endfunction

endpackage

// File: rtl/huffman_code_table.sv
// 64 x 12 code table: one write port, one read port with a registered
// (1-cycle) read. Contents are intentionally not touched by reset so a
// loaded table survives a decoder restart.
module huffman_code_table
  import huffman_pkg::*;
(
  input  logic             clock,
  input  logic             we,
  input  logic [SYM_W-1:0] waddr,
  input  logic [TBL_W-1:0] wdata,
  input  logic [SYM_W-1:0] raddr,
  output logic [TBL_W-1:0] rdata
);

  logic [TBL_W-1:0] mem_r [0:TBL_DEPTH-1];

  // Table write and synchronous read
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial Huffman decoder. Encoded words are appended to a 40-bit
// MSB-aligned bit buffer; the code table is scanned from address 0 upward
// (one entry per cycle) and the first entry matching the buffer head
// yields the symbol index. Optional symbol counter: HUFF_DEC_STATS_EN.
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              tbl_we,
  input  logic [SYM_W-1:0]  tbl_addr,
  input  logic [TBL_W-1:0]  tbl_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_bits,
  input  logic              in_last,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [SYM_W-1:0]  sym,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic [STAT_W-1:0] sym_count
);

  state_t             state_r, state_n;
  logic [BUF_W-1:0]   buf_r, buf_n;
  logic [CNT_W-1:0]   count_r, count_n;
  logic               last_seen_r, last_seen_n;
  logic [SYM_W-1:0]   sym_r, sym_n;
  logic [SCAN_W-1:0]  scan_r, scan_n;
  logic               done_n;

  logic               in_ready_r;
  logic               sym_valid_r;
  logic               done_r;
  logic               error_r;
  logic               busy_r;

  logic               tbl_we_s;
  logic [SYM_W-1:0]   rd_addr_s;
  logic [TBL_W-1:0]   rd_data_s;
  logic [CNT_W-1:0]   nbits_s;
  logic [WORD_W-1:0]  in_mask_s;
  logic [BUF_W-1:0]   place_s;
  logic               hit_s;
  logic [LEN_W-1:0]   hit_len_s;

  // The table may only be rewritten while the decoder holds no work
  assign tbl_we_s  = tbl_we & ~busy_r;
  // Scan counter value k issues address k; its data is compared at k+1
  assign rd_addr_s = scan_r[SYM_W-1:0];

  huffman_code_table u_table (
    .clock (clock),
    .we    (tbl_we_s),
    .waddr (tbl_addr),
    .wdata (tbl_data),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // Saturate the word bit count: 0 and anything above 32 mean a full word
  always_comb begin
    if ((in_bits == 6'd0) || (in_bits > 6'd32)) begin
      nbits_s = 6'd32;
    end else begin
      nbits_s = in_bits;
    end
  end

  // Keep only the valid leading bits of the word and align them behind
  // the bits already buffered
  always_comb begin
    in_mask_s = ~(32'hFFFF_FFFF >> nbits_s);
    place_s   = {in_data & in_mask_s, 8'h00} >> count_r;
  end

  // Compare the entry returned by the table against the buffer head
  always_comb begin
    hit_s     = code_match(rd_data_s, buf_r[BUF_W-1 -: CODE_W], count_r);
    hit_len_s = rd_data_s[LEN_MSB:LEN_LSB];
  end

  // Next-state, buffer and symbol update
  always_comb begin
    state_n     = state_r;
    buf_n       = buf_r;
    count_n     = count_r;
    last_seen_n = last_seen_r;
    sym_n       = sym_r;
    scan_n      = 7'd0;
    done_n      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_r >= 6'd8) || (last_seen_r && (count_r != 6'd0))) begin
          state_n = ST_SEARCH;
        end else if (last_seen_r) begin
          done_n      = 1'b1;
          last_seen_n = 1'b0;
        end else if (in_valid && in_ready_r) begin
          buf_n       = buf_r | place_s;
          count_n     = count_r + nbits_s;
          last_seen_n = in_last;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        scan_n = scan_r + 7'd1;
        if ((scan_r != 7'd0) && hit_s) begin
          sym_n   = scan_r[SYM_W-1:0] - 6'd1;
          buf_n   = buf_r << hit_len_s;
          count_n = count_r - {2'b00, hit_len_s};
          scan_n  = 7'd0;
          state_n = ST_EMIT;
        end else if (scan_r == 7'd64) begin
          scan_n = 7'd0;
          // Only an incomplete, non-final buffer may wait for more bits
          if (!last_seen_r && (count_r < 6'd8)) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_ERROR;
          end
        end else begin
          state_n = ST_SEARCH;
        end
      end
      ST_EMIT: begin
        if (sym_ready) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_EMIT;
        end
      end
      ST_ERROR: begin
        state_n = ST_ERROR;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register; outputs are registered from the next-state values so
  // they line up exactly with the state they describe
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      buf_r       <= '0;
      count_r     <= 6'd0;
      last_seen_r <= 1'b0;
      sym_r       <= 6'd0;
      scan_r      <= 7'd0;
      in_ready_r  <= 1'b1;
      sym_valid_r <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      buf_r       <= buf_n;
      count_r     <= count_n;
      last_seen_r <= last_seen_n;
      sym_r       <= sym_n;
      scan_r      <= scan_n;
      in_ready_r  <= (state_n == ST_IDLE) && (count_n < 6'd8) && !last_seen_n;
      sym_valid_r <= (state_n == ST_EMIT);
      done_r      <= done_n;
      error_r     <= (state_n == ST_ERROR);
      busy_r      <= (state_n != ST_IDLE) || (count_n != 6'd0);
    end
  end

  assign in_ready  = in_ready_r;
  assign sym_valid = sym_valid_r;
  assign sym       = sym_r;
  assign done      = done_r;
  assign error     = error_r;
  assign busy      = busy_r;

`ifdef HUFF_DEC_STATS_EN
  logic [STAT_W-1:0] sym_count_r;

  // Count delivered symbols, wrapping naturally at 16 bits
  always_ff @(posedge clock) begin
    if (reset) begin
      sym_count_r <= 16'd0;
    end else if (sym_valid_r && sym_ready) begin
      sym_count_r <= sym_count_r + 16'd1;
    end else begin
      sym_count_r <= sym_count_r;
    end
  end

  assign sym_count = sym_count_r;
`else
  assign sym_count = 16'd0;
`endif

endmodule
